// File: rtl/mem_controller_if.sv
// mem_controller_if: request/response bus between a requester (master) and mem_controller (slave)
interface mem_controller_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic req_valid;
  logic req_ready;
  logic [1:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic rsp_valid;
  logic [DATA_W-1:0] read_data;
  logic addr_err;
  modport master (
    output req_valid, op, addr, write_data,
    input req_ready, rsp_valid, read_data, addr_err
  );
  modport slave (
    input req_valid, op, addr, write_data,
    output req_ready, rsp_valid, read_data, addr_err
  );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: data memory with read/write/clear-sweep FSM plus an independent instruction fetch port.
// Defining MEM_PROG_LOAD_EN adds the prog_we/prog_addr/prog_wdata program-load port.
module mem_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 256,
  parameter int INSTR_W = 40
) (
  input logic clk,
  input logic reset,
  mem_controller_if.slave bus,
  input logic clear_req,
  output logic busy,
  input logic [ADDR_W-1:0] pc,
  input logic fetch_en,
  output logic [INSTR_W-1:0] current_instruction,
  output logic instr_valid
`ifdef MEM_PROG_LOAD_EN
  ,
  input logic prog_we,
  input logic [ADDR_W-1:0] prog_addr,
  input logic [INSTR_W-1:0] prog_wdata
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [INSTR_W-1:0] prog_mem [DEPTH];
  logic acc, is_rd, is_wr, in_rng, pc_in_rng, prog_in_rng, last;
`ifndef MEM_PROG_LOAD_EN
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_wdata;
  assign prog_we = 1'b0;
  assign prog_addr = '0;
  assign prog_wdata = '0;
`endif
  // clear_req has priority over a simultaneous request; reset drops anything presented alongside it
  assign acc = bus.req_valid && bus.req_ready && !clear_req && !reset;
  assign is_rd = bus.op == MEM_READ;
  assign is_wr = bus.op == MEM_WRITE;
  assign in_rng = {1'b0, bus.addr} < LIMIT;
  assign pc_in_rng = {1'b0, pc} < LIMIT;
  assign prog_in_rng = {1'b0, prog_addr} < LIMIT;
  assign last = idx == IW'(DEPTH - 1);
  always_ff @(posedge clk)
    state <= reset ? CLEAR : state_nx;
  always_comb
    state_nx = state == IDLE ? (clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  always_comb begin
    bus.req_ready = state == IDLE;
    busy = state == CLEAR;
  end
  always_ff @(posedge clk)
    if (reset || state == IDLE) idx <= '0;
    else idx <= idx + 1'b1;
  always_ff @(posedge clk)
    if (busy) data_mem[idx] <= '0;
    else if (acc && is_wr && in_rng) data_mem[bus.addr[IW-1:0]] <= bus.write_data;
  always_ff @(posedge clk)
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.read_data <= '0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rsp_valid <= acc && is_rd;
      bus.addr_err <= acc && (is_rd || is_wr) && !in_rng;
      if (acc && is_rd) bus.read_data <= in_rng ? data_mem[bus.addr[IW-1:0]] : '0;
    end
  always_ff @(posedge clk)
    if (prog_we && prog_in_rng) prog_mem[prog_addr[IW-1:0]] <= prog_wdata;
  always_ff @(posedge clk)
    if (reset) begin
      instr_valid <= 1'b0;
      current_instruction <= '0;
    end else begin
      instr_valid <= fetch_en;
      if (fetch_en) current_instruction <= pc_in_rng ? prog_mem[pc[IW-1:0]] : '0;
    end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: scoreboard bench for mem_controller; read/addr_err responses are queued at issue time.
module tb_mem_controller;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  typedef struct {
    logic rsp;
    logic err;
    logic [15:0] data;
    int due;
  } sb_t;
  logic clk = 0;
  logic reset = 1;
  logic clear_req = 0;
  logic fetch_en = 0;
  logic [15:0] pc = 0;
  logic busy, instr_valid;
  logic [39:0] current_instruction;
`ifdef MEM_PROG_LOAD_EN
  logic prog_we = 0;
  logic [15:0] prog_addr = 0;
  logic [39:0] prog_wdata = 0;
`endif
  mem_controller_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  sb_t sb[$];
  sb_t e;
  logic [15:0] model [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  mem_controller #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .INSTR_W(40)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .clear_req(clear_req),
    .busy(busy),
    .pc(pc),
    .fetch_en(fetch_en),
    .current_instruction(current_instruction),
    .instr_valid(instr_valid)
`ifdef MEM_PROG_LOAD_EN
    ,
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_wdata(prog_wdata)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (mon_en && (bus.rsp_valid === 1'b1 || bus.addr_err === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b addr_err=%b read_data=%h at cycle %0d, required no response",
                 bus.rsp_valid, bus.addr_err, bus.read_data, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_valid !== e.rsp || bus.addr_err !== e.err || (e.rsp && bus.read_data !== e.data) || cyc != e.due) begin
          errors++;
          $display("FAIL rsp: got rsp_valid=%b addr_err=%b read_data=%h cycle=%0d, required rsp_valid=%b addr_err=%b read_data=%h cycle=%0d",
                   bus.rsp_valid, bus.addr_err, bus.read_data, cyc, e.rsp, e.err, e.data, e.due);
        end
      end
    end
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d);
    sb_t x;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: got %b, required 1 before op=%0d addr=%h", bus.req_ready, o, a);
    end
    bus.req_valid = 1;
    bus.op = o;
    bus.addr = a;
    bus.write_data = d;
    x.rsp = o == RD;
    x.err = a >= 16'd256;
    x.data = a < 16'd256 ? model[a[7:0]] : 16'h0;
    x.due = cyc + 1;
    if (o == RD || (o == WR && a >= 16'd256)) sb.push_back(x);
    else if (o == WR) model[a[7:0]] = d;
    @(negedge clk);
    bus.req_valid = 0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    int n;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", bus.req_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", busy); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.read_data !== 16'h0) begin errors++; $display("FAIL reset_read_data: got %h, required 0", bus.read_data); end
    if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b, required 0", bus.addr_err); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid); end
    if (current_instruction !== 40'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", current_instruction); end
    reset = 0;
    mon_en = 1;
    count_busy(n);
    checks += 2;
    if (n != 256) begin errors++; $display("FAIL reset_busy_len: got %0d cycles, required 256", n); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b, required 1", bus.req_ready); end
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    issue(RD, 16'd5, 16'h0);
  endtask
  task automatic test_fetch;
    pc = 16'd300;
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    checks += 3;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_oor_valid: got %b, required 1", instr_valid); end
    if (current_instruction !== 40'h0) begin errors++; $display("FAIL fetch_oor_data: got %h, required 0", current_instruction); end
    @(negedge clk);
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b, required 0", instr_valid); end
`ifdef MEM_PROG_LOAD_EN
    prog_we = 1;
    prog_addr = 16'd7;
    prog_wdata = 40'h12_3456_789A;
    @(negedge clk);
    prog_we = 0;
`endif
    pc = 16'd7;
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b, required 1", instr_valid); end
`ifdef MEM_PROG_LOAD_EN
    checks++;
    if (current_instruction !== 40'h12_3456_789A) begin
      errors++;
      $display("FAIL fetch_load: got %h, required 123456789a", current_instruction);
    end
`endif
  endtask
  task automatic test_back_to_back;
    issue(WR, 16'h0010, 16'hBEEF);
    issue(RD, 16'h0010, 16'h0);
    issue(WR, 16'h0011, 16'h1111);
    issue(WR, 16'h0012, 16'h2222);
    issue(RD, 16'h0011, 16'h0);
    issue(RD, 16'h0012, 16'h0);
    issue(WR, 16'h0010, 16'h3333);
    issue(RD, 16'h0010, 16'h0);
  endtask
  task automatic test_out_of_range;
    issue(WR, 16'h0000, 16'h0F0F);
    issue(WR, 16'h00FF, 16'hF0F0);
    issue(WR, 16'h0100, 16'hAAAA);
    issue(RD, 16'h0100, 16'h0);
    issue(RD, 16'h0000, 16'h0);
    issue(WR, 16'hFFFF, 16'h5555);
    issue(RD, 16'hFFFF, 16'h0);
    issue(RD, 16'h00FF, 16'h0);
  endtask
  task automatic test_noop;
    issue(WR, 16'h0020, 16'h5A5A);
    issue(2'b00, 16'h0020, 16'h1111);
    issue(2'b11, 16'h0020, 16'h2222);
    issue(2'b11, 16'h0300, 16'h3333);
    issue(RD, 16'h0020, 16'h0);
  endtask
  task automatic test_hold;
    issue(WR, 16'd9, 16'hC0DE);
    issue(RD, 16'd9, 16'h0);
    repeat (3) @(negedge clk);
    checks += 2;
    if (bus.read_data !== 16'hC0DE) begin errors++; $display("FAIL hold_data: got %h, required c0de", bus.read_data); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b, required 0", bus.rsp_valid); end
  endtask
  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 7) == 0 ? 16'(256 + $urandom_range(0, 1000)) : 16'($urandom_range(0, 19));
      issue(2'($urandom_range(0, 3)), a, 16'($urandom));
    end
  endtask
  task automatic test_clear;
    int n;
    sb_t x;
    issue(WR, 16'd3, 16'h1234);
    issue(RD, 16'd3, 16'h0);
    clear_req = 1;
    bus.req_valid = 1;
    bus.op = RD;
    bus.addr = 16'd3;
    @(negedge clk);
    clear_req = 0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 1000) begin
      n++;
      clear_req = n == 50;
      @(negedge clk);
    end
    clear_req = 0;
    checks++;
    if (n != 256) begin errors++; $display("FAIL clear_len: got %0d not-ready cycles, required 256", n); end
    x.rsp = 1;
    x.err = 0;
    x.data = 16'h0;
    x.due = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    bus.req_valid = 0;
    issue(RD, 16'h0010, 16'h0);
    issue(RD, 16'h0020, 16'h0);
  endtask
  task automatic test_reset_mid_sweep;
    int n;
    issue(WR, 16'd200, 16'h7777);
    bus.req_valid = 1;
    bus.op = RD;
    bus.addr = 16'd200;
    reset = 1;
    @(negedge clk);
    bus.req_valid = 0;
    reset = 0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_drop: got rsp_valid=%b, required 0", bus.rsp_valid); end
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    count_busy(n);
    checks++;
    if (n != 256) begin errors++; $display("FAIL reset_idle_len: got %0d cycles, required 256", n); end
    issue(WR, 16'd200, 16'h8888);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (100) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
    count_busy(n);
    checks++;
    if (n != 256) begin errors++; $display("FAIL reset_mid_sweep: got %0d busy cycles, required 256", n); end
    issue(RD, 16'd200, 16'h0);
    issue(RD, 16'd5, 16'h0);
`ifdef MEM_PROG_LOAD_EN
    pc = 16'd7;
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    checks++;
    if (current_instruction !== 40'h12_3456_789A) begin
      errors++;
      $display("FAIL prog_after_reset: got %h, required 123456789a", current_instruction);
    end
`endif
  endtask
  initial begin
    bus.req_valid = 0;
    bus.op = 2'b00;
    bus.addr = 16'h0;
    bus.write_data = 16'h0;
    test_reset;
    test_fetch;
    test_back_to_back;
    test_out_of_range;
    test_noop;
    test_hold;
    test_random;
    test_clear;
    test_reset_mid_sweep;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain: got %0d pending responses, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, data word width; ADDR_W, 16, address width; DEPTH, 256, data/program words; INSTR_W, 40, instruction width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  data request present.
REQ-005 req_ready  out  1  controller accepts request this cycle.
REQ-006 op  in  2  instruction_set MEM_READ / MEM_WRITE; other values are no-op.
REQ-007 addr  in  ADDR_W  data address.
REQ-008 write_data  in  DATA_W  write word.
REQ-009 rsp_valid  out  1  one-cycle pulse: read_data valid.
REQ-010 read_data  out  DATA_W  registered read result.
REQ-011 addr_err  out  1  one-cycle pulse: accepted request had addr >= DEPTH.
REQ-012 clear_req  in  1  start full data-memory clear.
REQ-013 busy  out  1  clear sweep in progress.
REQ-014 pc  in  ADDR_W  fetch address; fetch_en  in  1  fetch strobe.
REQ-015 current_instruction  out  INSTR_W  registered instruction; instr_valid  out  1  pulse.

Function
REQ-016 Request SHALL be accepted when req_valid && req_ready; req_ready = (state == IDLE).
REQ-017 Accepted MEM_WRITE, addr < DEPTH, SHALL update data_mem[addr] at that edge; no rsp_valid.
REQ-018 Accepted MEM_READ SHALL drive read_data = data_mem[addr] with rsp_valid high exactly one cycle later (latency 1).
REQ-019 read_data SHALL hold its last value while rsp_valid is low.
REQ-020 Read in cycle N+1 of a write accepted in cycle N to same address SHALL return new data.
REQ-021 Accepted request with addr >= DEPTH SHALL not modify memory; read returns 0 with rsp_valid; addr_err pulses one cycle later.
REQ-022 Accepted no-op op SHALL produce no rsp_valid, no addr_err, no memory change.
REQ-023 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clear_req or reset; CLEAR->IDLE after writing index DEPTH-1.
REQ-024 CLEAR SHALL zero one word per cycle, index 0..DEPTH-1 ascending, taking exactly DEPTH cycles; busy = (state == CLEAR).
REQ-025 clear_req during CLEAR SHALL be ignored (no restart); clear_req and req_valid together in IDLE: clear wins, request not accepted.
REQ-026 Fetch SHALL be independent of FSM: fetch_en in cycle N yields prog_mem[pc] and instr_valid in N+1; pc >= DEPTH yields 0.
REQ-027 Program memory SHALL be read-only in RTL except as in REQ-033.

Reset
REQ-028 reset SHALL force state CLEAR with index 0, restarting any sweep in progress.
REQ-029 Reset values: req_ready 0, busy 1, rsp_valid 0, read_data 0, addr_err 0, instr_valid 0, current_instruction 0.
REQ-030 Request or read in flight at reset SHALL be dropped; no rsp_valid after reset.
REQ-031 Program memory contents SHALL not be altered by reset.

Configuration
REQ-032 Macro MEM_PROG_LOAD_EN SHALL select the program-load port.
REQ-033 Defined: ports prog_we (in, 1), prog_addr (in, ADDR_W), prog_wdata (in, INSTR_W) exist; prog_we with prog_addr < DEPTH writes prog_mem at edge; fetch same address next cycle returns new word.
REQ-034 Undefined: those ports SHALL be absent; prog_mem content only by simulation preload.

Verification
REQ-035 Reset 1 cycle, release -> busy high 256 cycles, req_ready rises in cycle 257, read of addr 5 returns 0.
REQ-036 Write 0xBEEF @0x10 cycle N, read @0x10 cycle N+1 -> rsp_valid and read_data 0xBEEF in N+2.
REQ-037 Read @0x0100 (DEPTH 256) -> read_data 0, rsp_valid 1, addr_err 1 next cycle; memory unchanged.
REQ-038 Write 0x1234 @3, clear_req, req_valid held during sweep -> req_ready 0 for 256 cycles, then read @3 returns 0.
REQ-039 Reset asserted at sweep index 100 -> sweep restarts at 0, busy total 256 cycles after release.
REQ-040 With MEM_PROG_LOAD_EN: load 0x12_3456_789A @7, fetch pc 7 -> instr_valid and current_instruction 0x123456789A next cycle.
